// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. One digit per refresh slot, a blank gap at the start
// of every slot, and display data double-buffered so that new values only
// take effect at frame boundaries.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned LZ_SUPPRESS  = 0
) (
    input  logic        clk,
    input  logic        rst_btn,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    input  logic        load_i,
    output logic [3:0]  anodes_o,
    output logic [7:0]  segments_o,
    output logic        frame_start_o
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // cnt_q/dig_q name the cycle that the next clock edge enters, so the
    // outputs registered on that edge belong exactly to that cycle.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;

    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic [3:0]    pend_blank_q, pend_blank_d;
    logic          pend_flag_q, pend_flag_d;

    logic [15:0]   sh_data_q, sh_data_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_blank_q, sh_blank_d;

    logic [3:0]    anodes_d;
    logic [7:0]    segments_d;
    logic          frame_start_d;

    logic          boundary;
    logic [3:0]    nib;
    logic          lz_dark;
    logic          dark;

    // Next-state: scan position, pending/shadow buffers and output values.
    always_comb begin
        boundary = (cnt_q == '0) && (dig_q == 2'd0);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            dig_d = dig_q;
        end

        // Shadow takes pending only if the flag was set before this cycle;
        // a load in the boundary cycle lands in pending for the next frame.
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (boundary && pend_flag_q) begin
            sh_data_d  = pend_data_q;
            sh_dp_d    = pend_dp_q;
            sh_blank_d = pend_blank_q;
        end

        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        if (load_i) begin
            pend_data_d  = data_i;
            pend_dp_d    = dp_i;
            pend_blank_d = blank_i;
        end
        pend_flag_d = load_i | (pend_flag_q & ~boundary);

        // Decode from the shadow value in effect for this cycle.
        nib     = sh_data_d[{dig_q, 2'b00} +: 4];
        lz_dark = (LZ_SUPPRESS != 0) && (dig_q != 2'd0) &&
                  ((sh_data_d >> {dig_q, 2'b00}) == 16'h0000);
        dark    = sh_blank_d[dig_q] | lz_dark;

        if (cnt_q < CNT_BLANK) begin
            anodes_d   = '1;
            segments_d = '1;
        end else begin
            anodes_d   = ~(4'b0001 << dig_q);
            segments_d = dark ? '1 : {~sh_dp_d[dig_q], hex7(nib)};
        end

        frame_start_d = boundary;
    end

    // State and registered outputs, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            cnt_q         <= '0;
            dig_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_flag_q   <= 1'b0;
            sh_data_q     <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            anodes_o      <= '1;
            segments_o    <= '1;
            frame_start_o <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_flag_q   <= pend_flag_d;
            sh_data_q     <= sh_data_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            anodes_o      <= anodes_d;
            segments_o    <= segments_d;
            frame_start_o <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero suppression off
// and on) share stimulus and are compared every cycle to a frame-level
// reference model.
module tb_seg_scan_driver;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_btn = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        load_i = 1'b0;
    logic [3:0]  an0, an1;
    logic [7:0]  seg0, seg1;
    logic        fs0, fs1;

    seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(0)) u0 (
        .clk(clk), .rst_btn(rst_btn), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
        .load_i(load_i), .anodes_o(an0), .segments_o(seg0), .frame_start_o(fs0));

    seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1)) u1 (
        .clk(clk), .rst_btn(rst_btn), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
        .load_i(load_i), .anodes_o(an1), .segments_o(seg1), .frame_start_o(fs1));

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [6:0]  HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int unsigned t;      // index of the next cycle since reset release
    int unsigned cur;    // index of the cycle just completed
    logic        rel = 1'b0;
    logic [15:0] m_sd, m_pd;
    logic [3:0]  m_sp, m_sb, m_pp, m_pb;
    logic        m_pf;
    logic [3:0]  exp_an;
    logic [7:0]  exp_s0, exp_s1;
    logic        exp_fs;

    function automatic logic [7:0] model_seg(input int unsigned d, input bit lz);
        logic [3:0] n;
        n = 4'((m_sd >> (4 * d)) & 16'hF);
        if (m_sb[d] || (lz && d > 0 && (m_sd >> (4 * d)) == 0)) return 8'hFF;
        return {~m_sp[d], HEX[n]};
    endfunction

    task automatic model_reset();
        t = 0; m_sd = '0; m_pd = '0; m_sp = '0; m_sb = '0; m_pp = '0; m_pb = '0; m_pf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, leave time at edge+1.
    task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl);
        int unsigned dig, off;
        @(negedge clk);
        if (rel) begin rst_btn = 1'b1; rel = 1'b0; end
        load_i = ld; data_i = d; dp_i = dp; blank_i = bl;
        @(posedge clk);
        if (t % FRAME == 0 && m_pf) begin
            m_sd = m_pd; m_sp = m_pp; m_sb = m_pb; m_pf = 1'b0;
        end
        if (ld) begin m_pd = d; m_pp = dp; m_pb = bl; m_pf = 1'b1; end
        dig = (t / DIV) % 4;
        off = t % DIV;
        exp_fs = (t % FRAME == 0);
        if (off < BLANK) begin
            exp_an = 4'hF; exp_s0 = 8'hFF; exp_s1 = 8'hFF;
        end else begin
            exp_an = ~(4'b0001 << dig);
            exp_s0 = model_seg(dig, 1'b0);
            exp_s1 = model_seg(dig, 1'b1);
        end
        cur = t;
        t++;
        #1;
    endtask

    task automatic test_reset();
        rst_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load_i = (i % 2 == 0); data_i = 16'hBEEF; dp_i = 4'hF; blank_i = 4'h0;
            @(posedge clk); #1;
            checks++;
            if (an0 !== 4'hF || an1 !== 4'hF || seg0 !== 8'hFF || seg1 !== 8'hFF ||
                fs0 !== 1'b0 || fs1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold an=%h/%h seg=%h/%h fs=%b/%b exp an=F seg=FF fs=0",
                         an0, an1, seg0, seg1, fs0, fs1);
            end
        end
        model_reset();
        rel = 1'b1;
    endtask

    task automatic test_basic();
        int unsigned base = t;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle(i == 0, 16'h1234, 4'h0, 4'h0);
            checks++;
            if (an0 !== exp_an || an1 !== exp_an) begin errors++;
                $display("FAIL basic_an t=%0d got=%h/%h exp=%h", cur, an0, an1, exp_an); end
            checks++;
            if (seg0 !== exp_s0 || seg1 !== exp_s1) begin errors++;
                $display("FAIL basic_seg t=%0d got=%h/%h exp=%h/%h", cur, seg0, seg1, exp_s0, exp_s1); end
            checks++;
            if (fs0 !== exp_fs || fs1 !== exp_fs) begin errors++;
                $display("FAIL basic_fs t=%0d got=%b/%b exp=%b", cur, fs0, fs1, exp_fs); end
            if (cur == base + FRAME + 2) begin
                checks++;
                if (an0 !== 4'hE || seg0 !== 8'h99) begin errors++;
                    $display("FAIL basic_digit0 got an=%h seg=%h exp an=E seg=99", an0, seg0); end
            end
            if (cur == base + FRAME + DIV + 2) begin
                checks++;
                if (an0 !== 4'hD || seg0 !== 8'hB0) begin errors++;
                    $display("FAIL basic_digit1 got an=%h seg=%h exp an=D seg=B0", an0, seg0); end
            end
            if (cur == base + FRAME + 3 * DIV + 1) begin
                checks++;
                if (an0 !== 4'hF || seg0 !== 8'hFF) begin errors++;
                    $display("FAIL basic_gap got an=%h seg=%h exp an=F seg=FF", an0, seg0); end
            end
        end
    endtask

    task automatic test_last_load_wins();
        int unsigned base = t;
        logic ld;
        logic [15:0] d;
        for (int i = 0; i < 2 * FRAME; i++) begin
            ld = (i == 10 || i == 26);
            d  = (i == 10) ? 16'hAAAA : 16'h5555;
            cycle(ld, d, 4'h0, 4'h0);
            checks++;
            if (an0 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1 || fs0 !== exp_fs) begin errors++;
                $display("FAIL lastload t=%0d got an=%h seg=%h/%h fs=%b exp an=%h seg=%h/%h fs=%b",
                         cur, an0, seg0, seg1, fs0, exp_an, exp_s0, exp_s1, exp_fs); end
            if (cur == base + 2 * DIV + 2) begin
                checks++;
                if (seg0 !== 8'hA4) begin errors++;
                    $display("FAIL lastload_old got seg=%h exp=A4", seg0); end
            end
            if (cur == base + FRAME + 3 * DIV + 2) begin
                checks++;
                if (an0 !== 4'h7 || seg0 !== 8'h92) begin errors++;
                    $display("FAIL lastload_new got an=%h seg=%h exp an=7 seg=92", an0, seg0); end
            end
        end
    endtask

    task automatic test_lz();
        int unsigned base = t;
        logic ld;
        logic [15:0] d;
        for (int i = 0; i < 3 * FRAME; i++) begin
            ld = (i == 1 || i == 52);
            d  = (i == 1) ? 16'h0005 : 16'h0000;
            cycle(ld, d, 4'h0, 4'h0);
            checks++;
            if (an0 !== exp_an || an1 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1) begin errors++;
                $display("FAIL lz t=%0d got an=%h/%h seg=%h/%h exp an=%h seg=%h/%h",
                         cur, an0, an1, seg0, seg1, exp_an, exp_s0, exp_s1); end
            if (cur == base + FRAME + 2) begin
                checks++;
                if (seg1 !== 8'h92) begin errors++;
                    $display("FAIL lz_d0 got seg=%h exp=92", seg1); end
            end
            if (cur == base + FRAME + 3 * DIV + 4) begin
                checks++;
                if (an1 !== 4'h7 || seg1 !== 8'hFF || seg0 !== 8'hC0) begin errors++;
                    $display("FAIL lz_d3 got an=%h seg=%h/%h exp an=7 seg=C0/FF", an1, seg0, seg1); end
            end
            if (cur == base + 2 * FRAME + 2) begin
                checks++;
                if (seg1 !== 8'hC0) begin errors++;
                    $display("FAIL lz_zero got seg=%h exp=C0", seg1); end
            end
        end
    endtask

    task automatic test_blank_dp();
        int unsigned base = t;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle(i == 3, 16'h8888, 4'b0001, 4'b0010);
            checks++;
            if (an0 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1) begin errors++;
                $display("FAIL blankdp t=%0d got an=%h seg=%h/%h exp an=%h seg=%h/%h",
                         cur, an0, seg0, seg1, exp_an, exp_s0, exp_s1); end
            if (cur >= base + FRAME && (cur - base - FRAME) % DIV == 3) begin
                checks++;
                case ((cur - base - FRAME) / DIV)
                    0: if (seg0 !== 8'h00) begin errors++; $display("FAIL blankdp_d0 got=%h exp=00", seg0); end
                    1: if (seg0 !== 8'hFF || an0 !== 4'hD) begin errors++;
                           $display("FAIL blankdp_d1 got an=%h seg=%h exp an=D seg=FF", an0, seg0); end
                    default: if (seg0 !== 8'h80) begin errors++; $display("FAIL blankdp_d23 got=%h exp=80", seg0); end
                endcase
            end
        end
    endtask

    task automatic test_boundary_load();
        int unsigned base = t;
        logic ld;
        logic [15:0] d;
        for (int i = 0; i < 3 * FRAME; i++) begin
            ld = (i == FRAME - 1 || i == FRAME);
            d  = (i == FRAME - 1) ? 16'h00F0 : 16'h0F00;
            cycle(ld, d, 4'h0, 4'h0);
            checks++;
            if (an0 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1 || fs0 !== exp_fs) begin errors++;
                $display("FAIL boundary t=%0d got an=%h seg=%h/%h fs=%b exp an=%h seg=%h/%h fs=%b",
                         cur, an0, seg0, seg1, fs0, exp_an, exp_s0, exp_s1, exp_fs); end
            if (cur == base + FRAME + DIV + 2 || cur == base + 2 * FRAME + 2 * DIV + 2) begin
                checks++;
                if (seg0 !== 8'h8E) begin errors++; $display("FAIL boundary_f got=%h exp=8E", seg0); end
            end
            if (cur == base + FRAME + 2 * DIV + 2) begin
                checks++;
                if (seg0 !== 8'hC0) begin errors++; $display("FAIL boundary_defer got=%h exp=C0", seg0); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * FRAME; i++) begin
            cycle(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
            checks++;
            if (an0 !== exp_an || an1 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1 ||
                fs0 !== exp_fs || fs1 !== exp_fs) begin errors++;
                $display("FAIL random t=%0d got an=%h/%h seg=%h/%h fs=%b/%b exp an=%h seg=%h/%h fs=%b",
                         cur, an0, an1, seg0, seg1, fs0, fs1, exp_an, exp_s0, exp_s1, exp_fs); end
        end
    endtask

    task automatic test_mid_reset();
        // stop at digit 2, mid-slot, with a pending update outstanding
        while (!(t % FRAME == 2 * DIV + 5)) cycle(t % FRAME == 3, 16'hFFFF, 4'hF, 4'h0);
        #1 rst_btn = 1'b0;
        #1;
        checks++;
        if (an0 !== 4'hF || seg0 !== 8'hFF || fs0 !== 1'b0 || an1 !== 4'hF || seg1 !== 8'hFF) begin errors++;
            $display("FAIL midreset_async got an=%h seg=%h fs=%b exp an=F seg=FF fs=0", an0, seg0, fs0); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (an0 !== 4'hF || seg0 !== 8'hFF || fs0 !== 1'b0) begin errors++;
                $display("FAIL midreset_hold got an=%h seg=%h fs=%b exp an=F seg=FF fs=0", an0, seg0, fs0); end
        end
        model_reset();
        rel = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle(1'b0, 16'h0, 4'h0, 4'h0);
            checks++;
            if (an0 !== exp_an || seg0 !== exp_s0 || seg1 !== exp_s1 || fs0 !== exp_fs) begin errors++;
                $display("FAIL midreset t=%0d got an=%h seg=%h/%h fs=%b exp an=%h seg=%h/%h fs=%b",
                         cur, an0, seg0, seg1, fs0, exp_an, exp_s0, exp_s1, exp_fs); end
            if (cur == 2) begin
                checks++;
                if (an0 !== 4'hE || seg0 !== 8'hC0) begin errors++;
                    $display("FAIL midreset_d0 got an=%h seg=%h exp an=E seg=C0", an0, seg0); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_last_load_wins();
        test_lz();
        test_blank_dp();
        test_boundary_load();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
